// File: rtl/sdspi_mem_dumper.sv
// Reads DUMP_SIZE bytes of memory word by word and streams them LSB-first to an SD sector writer.
// Optional macro DUMPER_SECTOR_PAD_EN zero-pads the stream to a 512-byte sector boundary.
module sdspi_mem_dumper #(
   parameter logic [31:0] DUMP_SIZE = 32'd4096,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk27mhz,
   input  logic        resetn,
   input  logic        start,
   input  logic [7:0]  w_ctrl_state,
   output logic        RE,
   output logic [31:0] ADDR,
   input  logic [31:0] RDATA,
   input  logic        RVALID,
   output logic        outen,
   output logic [7:0]  outbyte,
   input  logic        outready,
   output logic [31:0] byte_cnt,
   output logic        busy,
   output logic        DONE
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_PAD   = 3'd4,
      ST_FIN   = 3'd5
   } state_t;

   state_t      state_r, state_s;
   logic        re_r, re_s;
   logic [31:0] addr_r, addr_s;
   logic        outen_r, outen_s;
   logic [7:0]  outbyte_r, outbyte_s;
   logic [31:0] byte_cnt_r, byte_cnt_s;
   logic        busy_r, busy_s;
   logic        done_r, done_s;
   logic [23:0] shreg_r, shreg_s;
   logic [1:0]  idx_r, idx_s;
   logic        xfer_s;
   logic [31:0] cnt_inc_s;

   assign RE       = re_r;
   assign ADDR     = addr_r;
   assign outen    = outen_r;
   assign outbyte  = outbyte_r;
   assign byte_cnt = byte_cnt_r;
   assign busy     = busy_r;
   assign DONE     = done_r;

   // Next-state and next-output computation for every registered output.
   always_comb begin
      state_s    = state_r;
      re_s       = re_r;
      addr_s     = addr_r;
      outen_s    = outen_r;
      outbyte_s  = outbyte_r;
      byte_cnt_s = byte_cnt_r;
      busy_s     = busy_r;
      done_s     = done_r;
      shreg_s    = shreg_r;
      idx_s      = idx_r;
      xfer_s     = outen_r & outready;
      cnt_inc_s  = byte_cnt_r + 32'd1;
      case (state_r)
         ST_IDLE, ST_FIN: begin
            if (start) begin
               addr_s     = BASE_ADDR;
               byte_cnt_s = 32'd0;
               busy_s     = 1'b1;
               done_s     = 1'b0;
               re_s       = 1'b0;
               outen_s    = 1'b0;
               state_s    = ST_REQ;
            end else begin
               state_s = state_r;
            end
         end
         ST_REQ: begin
            if (w_ctrl_state == 8'd0) begin
               re_s    = 1'b1;
               state_s = ST_WAIT;
            end else begin
               re_s = 1'b0;
            end
         end
         ST_WAIT: begin
            // RE is held until the controller leaves idle, i.e. has taken the request.
            if (w_ctrl_state != 8'd0) begin
               re_s = 1'b0;
            end else begin
               re_s = re_r;
            end
            if (RVALID) begin
               re_s      = 1'b0;
               shreg_s   = RDATA[31:8];
               outbyte_s = RDATA[7:0];
               outen_s   = 1'b1;
               idx_s     = 2'd0;
               state_s   = ST_SHIFT;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_SHIFT: begin
            if (xfer_s) begin
               byte_cnt_s = cnt_inc_s;
               if (idx_r == 2'd3) begin
                  outen_s = 1'b0;
                  if (cnt_inc_s < DUMP_SIZE) begin
                     addr_s  = addr_r + 32'd4;
                     state_s = ST_REQ;
                  end else begin
`ifdef DUMPER_SECTOR_PAD_EN
                     if (cnt_inc_s[8:0] == 9'd0) begin
                        state_s = ST_FIN;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        re_s    = 1'b0;
                     end else begin
                        outen_s   = 1'b1;
                        outbyte_s = 8'h00;
                        state_s   = ST_PAD;
                     end
`else
                     state_s = ST_FIN;
                     done_s  = 1'b1;
                     busy_s  = 1'b0;
                     re_s    = 1'b0;
`endif
                  end
               end else begin
                  idx_s     = idx_r + 2'd1;
                  outbyte_s = shreg_r[7:0];
                  shreg_s   = {8'h00, shreg_r[23:8]};
               end
            end else begin
               state_s = ST_SHIFT;
            end
         end
`ifdef DUMPER_SECTOR_PAD_EN
         ST_PAD: begin
            if (xfer_s) begin
               byte_cnt_s = cnt_inc_s;
               if (cnt_inc_s[8:0] == 9'd0) begin
                  outen_s = 1'b0;
                  state_s = ST_FIN;
                  done_s  = 1'b1;
                  busy_s  = 1'b0;
                  re_s    = 1'b0;
               end else begin
                  outbyte_s = 8'h00;
               end
            end else begin
               state_s = ST_PAD;
            end
         end
`endif
         default: begin
            state_s = ST_IDLE;
            re_s    = 1'b0;
            outen_s = 1'b0;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk27mhz or negedge resetn) begin
      if (!resetn) begin
         state_r    <= ST_IDLE;
         re_r       <= 1'b0;
         addr_r     <= BASE_ADDR;
         outen_r    <= 1'b0;
         outbyte_r  <= 8'h00;
         byte_cnt_r <= 32'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         shreg_r    <= 24'h0;
         idx_r      <= 2'd0;
      end else begin
         state_r    <= state_s;
         re_r       <= re_s;
         addr_r     <= addr_s;
         outen_r    <= outen_s;
         outbyte_r  <= outbyte_s;
         byte_cnt_r <= byte_cnt_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
         shreg_r    <= shreg_s;
         idx_r      <= idx_s;
      end
   end

endmodule

// File: tb/tb_sdspi_mem_dumper.sv
// Directed bench for sdspi_mem_dumper (DUMP_SIZE=8, BASE_ADDR=0x100); pad expectations
// follow DUMPER_SECTOR_PAD_EN.
module tb_sdspi_mem_dumper;

   logic        clk27mhz;
   logic        resetn;
   logic        start;
   logic [7:0]  w_ctrl_state;
   logic        RE;
   logic [31:0] ADDR;
   logic [31:0] RDATA;
   logic        RVALID;
   logic        outen;
   logic [7:0]  outbyte;
   logic        outready;
   logic [31:0] byte_cnt;
   logic        busy;
   logic        DONE;

   int n_cmp;
   int n_err;

   sdspi_mem_dumper #(
      .DUMP_SIZE(32'd8),
      .BASE_ADDR(32'h100)
   ) dut (
      .clk27mhz    (clk27mhz),
      .resetn      (resetn),
      .start       (start),
      .w_ctrl_state(w_ctrl_state),
      .RE          (RE),
      .ADDR        (ADDR),
      .RDATA       (RDATA),
      .RVALID      (RVALID),
      .outen       (outen),
      .outbyte     (outbyte),
      .outready    (outready),
      .byte_cnt    (byte_cnt),
      .busy        (busy),
      .DONE        (DONE)
   );

   initial clk27mhz = 1'b0;
   always #5 clk27mhz = ~clk27mhz;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Serve one memory read: release controller, wait for RE, accept, return data.
   task automatic fetch(input logic [31:0] d, input logic [31:0] exp_addr, input int hold);
      w_ctrl_state = 8'h00;
      @(negedge clk27mhz);
      for (int k = 0; k < 20 && RE !== 1'b1; k++) @(negedge clk27mhz);
      check_val("re_rise", {31'd0, RE}, 32'd1);
      check_val("addr", ADDR, exp_addr);
      repeat (hold) @(negedge clk27mhz);
      check_val("re_hold", {31'd0, RE}, 32'd1);
      w_ctrl_state = 8'h01;
      @(negedge clk27mhz);
      check_val("re_fall", {31'd0, RE}, 32'd0);
      RVALID = 1'b1;
      RDATA  = d;
      @(negedge clk27mhz);
      RVALID = 1'b0;
      RDATA  = 32'h0;
   endtask

   // Accept n bytes of word d starting at byte index first, outready held high.
   task automatic stream(input logic [31:0] d, input int first, input int n, input logic [31:0] cnt0);
      logic [7:0] b;
      for (int i = first; i < first + n; i++) begin
         b = d[8*i +: 8];
         check_val("outen", {31'd0, outen}, 32'd1);
         check_val("outbyte", {24'd0, outbyte}, {24'd0, b});
         outready = 1'b1;
         @(negedge clk27mhz);
         check_val("byte_cnt", byte_cnt, cnt0 + 32'(i - first + 1));
      end
      outready = 1'b0;
   endtask

   initial begin
      int  npad;
      logic zero_ok;
      n_cmp = 0;
      n_err = 0;
      resetn = 1'b0; start = 1'b0; w_ctrl_state = 8'h05;
      RDATA = 32'h0; RVALID = 1'b0; outready = 1'b0;
      repeat (2) @(negedge clk27mhz);
      check_val("rst_re", {31'd0, RE}, 32'd0);
      check_val("rst_addr", ADDR, 32'h100);
      check_val("rst_outen", {31'd0, outen}, 32'd0);
      check_val("rst_outbyte", {24'd0, outbyte}, 32'd0);
      check_val("rst_cnt", byte_cnt, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_done", {31'd0, DONE}, 32'd0);

      resetn = 1'b1;
      outready = 1'b1;
      repeat (3) @(negedge clk27mhz);
      outready = 1'b0;
      check_val("idle_busy", {31'd0, busy}, 32'd0);
      check_val("idle_re", {31'd0, RE}, 32'd0);
      check_val("idle_outen", {31'd0, outen}, 32'd0);

      start = 1'b1;
      @(negedge clk27mhz);
      start = 1'b0;
      check_val("start_busy", {31'd0, busy}, 32'd1);
      check_val("start_addr", ADDR, 32'h100);
      check_val("start_cnt", byte_cnt, 32'd0);
      repeat (3) @(negedge clk27mhz);
      check_val("re_ctrl_busy", {31'd0, RE}, 32'd0);

      fetch(32'hAABBCCDD, 32'h100, 2);
      check_val("w0_outen", {31'd0, outen}, 32'd1);
      check_val("w0_b0", {24'd0, outbyte}, 32'h0000_00DD);
      outready = 1'b1;
      @(negedge clk27mhz);
      outready = 1'b0;
      check_val("w0_cnt1", byte_cnt, 32'd1);
      check_val("w0_b1", {24'd0, outbyte}, 32'h0000_00CC);
      // stall with spurious start and RVALID while shifting
      start = 1'b1; RVALID = 1'b1; RDATA = 32'hDEADBEEF;
      @(negedge clk27mhz);
      start = 1'b0; RVALID = 1'b0; RDATA = 32'h0;
      repeat (9) @(negedge clk27mhz);
      check_val("stall_byte", {24'd0, outbyte}, 32'h0000_00CC);
      check_val("stall_cnt", byte_cnt, 32'd1);
      check_val("stall_outen", {31'd0, outen}, 32'd1);
      check_val("stall_busy", {31'd0, busy}, 32'd1);
      stream(32'hAABBCCDD, 1, 3, 32'd1);
      check_val("w0_end_outen", {31'd0, outen}, 32'd0);
      check_val("w0_end_addr", ADDR, 32'h104);

      fetch(32'h11223344, 32'h104, 0);
      stream(32'h11223344, 0, 4, 32'd4);
`ifdef DUMPER_SECTOR_PAD_EN
      npad = 0;
      zero_ok = 1'b1;
      outready = 1'b1;
      while (outen === 1'b1 && npad < 1000) begin
         if (outbyte !== 8'h00) zero_ok = 1'b0;
         npad++;
         @(negedge clk27mhz);
      end
      outready = 1'b0;
      check_val("pad_count", 32'(npad), 32'd504);
      check_val("pad_zero", {31'd0, zero_ok}, 32'd1);
      check_val("fin_cnt", byte_cnt, 32'd512);
`else
      npad = 0;
      zero_ok = 1'b1;
      check_val("fin_cnt", byte_cnt, 32'd8);
`endif
      check_val("fin_done", {31'd0, DONE}, 32'd1);
      check_val("fin_busy", {31'd0, busy}, 32'd0);
      check_val("fin_outen", {31'd0, outen}, 32'd0);
      check_val("fin_re", {31'd0, RE}, 32'd0);

      start = 1'b1;
      @(negedge clk27mhz);
      start = 1'b0;
      check_val("restart_done", {31'd0, DONE}, 32'd0);
      check_val("restart_busy", {31'd0, busy}, 32'd1);
      check_val("restart_addr", ADDR, 32'h100);
      check_val("restart_cnt", byte_cnt, 32'd0);
      fetch(32'hAABBCCDD, 32'h100, 0);
      stream(32'hAABBCCDD, 0, 2, 32'd0);
`ifdef DUMPER_SECTOR_PAD_EN
      stream(32'hAABBCCDD, 2, 2, 32'd2);
      fetch(32'h11223344, 32'h104, 0);
      stream(32'h11223344, 0, 4, 32'd4);
      outready = 1'b1;
      repeat (292) @(negedge clk27mhz);
      outready = 1'b0;
      check_val("midpad_cnt", byte_cnt, 32'd300);
`endif
      resetn = 1'b0;
      #1;
      check_val("arst_re", {31'd0, RE}, 32'd0);
      check_val("arst_addr", ADDR, 32'h100);
      check_val("arst_outen", {31'd0, outen}, 32'd0);
      check_val("arst_outbyte", {24'd0, outbyte}, 32'd0);
      check_val("arst_cnt", byte_cnt, 32'd0);
      check_val("arst_busy", {31'd0, busy}, 32'd0);
      check_val("arst_done", {31'd0, DONE}, 32'd0);
      @(negedge clk27mhz);
      resetn = 1'b1;
      @(negedge clk27mhz);
      check_val("post_rst_busy", {31'd0, busy}, 32'd0);
      start = 1'b1;
      @(negedge clk27mhz);
      start = 1'b0;
      check_val("again_addr", ADDR, 32'h100);
      check_val("again_cnt", byte_cnt, 32'd0);
      fetch(32'h55667788, 32'h100, 0);
      stream(32'h55667788, 0, 4, 32'd0);
      check_val("again_addr2", ADDR, 32'h104);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sdspi_mem_dumper.md
SDSPI_MEM_DUMPER -- requirements
Module: sdspi_mem_dumper

Interface
REQ-001 SHALL have parameter DUMP_SIZE, default 32'd4096: bytes to read from memory; a multiple of 4, at least 4.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0: byte address of the first word read.
REQ-003 SHALL have port clk27mhz, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, begins a dump when sampled high in IDLE or FIN.
REQ-006 SHALL have port w_ctrl_state, input, 8, memory controller state; 0 means the controller is idle.
REQ-007 SHALL have port RE, output, 1, memory read request.
REQ-008 SHALL have port ADDR, output, 32, byte address of the current read.
REQ-009 SHALL have port RDATA, input, 32, read word from memory.
REQ-010 SHALL have port RVALID, input, 1, RDATA valid for one cycle.
REQ-011 SHALL have port outen, output, 1, outbyte valid toward the SD sector writer.
REQ-012 SHALL have port outbyte, output, 8, byte stream data.
REQ-013 SHALL have port outready, input, 1, the sector writer accepts the byte.
REQ-014 SHALL have port byte_cnt, output, 32, bytes accepted so far, including pad bytes.
REQ-015 SHALL have ports busy, output, 1, and DONE, output, 1: a dump is in progress; the dump is complete (sticky).

Function
REQ-016 SHALL implement the states IDLE, REQ, WAIT, SHIFT, PAD and FIN.
REQ-017 IDLE: on start, SHALL set ADDR=BASE_ADDR, byte_cnt=0 and busy=1, then go to REQ.
REQ-018 REQ: when w_ctrl_state==0, SHALL assert RE and go to WAIT; otherwise it SHALL hold.
REQ-019 WAIT: SHALL deassert RE in the first cycle w_ctrl_state!=0 and SHALL hold RE high until then.
REQ-020 WAIT: on RVALID, SHALL capture RDATA into a 32-bit shift register and go to SHIFT.
REQ-021 SHALL ignore RVALID outside WAIT.
REQ-022 SHIFT: SHALL assert outen from the cycle after capture, presenting bytes LSB first (RDATA[7:0] first).
REQ-023 A byte SHALL transfer only on a clock edge where outen&&outready.
REQ-024 outbyte SHALL stay stable while outen=1 and outready=0.
REQ-025 Each transfer SHALL increment byte_cnt by 1 (32-bit, wraps modulo 2^32).
REQ-026 After the 4th transfer of a word, if byte_cnt<DUMP_SIZE, SHALL set ADDR+=4, drop outen and go to REQ.
REQ-027 After the 4th transfer of a word, if byte_cnt==DUMP_SIZE, SHALL go to PAD (see Configuration).
REQ-028 PAD: SHALL present outbyte=8'h00 with outen=1 until byte_cnt[8:0]==0, then go to FIN.
REQ-029 PAD: if byte_cnt[8:0]==0 on entry, SHALL emit no pad bytes.
REQ-030 FIN: SHALL set DONE=1, busy=0, outen=0 and RE=0.
REQ-031 FIN: on start, SHALL clear DONE and restart as from IDLE in the same cycle.
REQ-032 SHALL ignore start while busy=1.
REQ-033 outready SHALL be ignored while outen=0.
REQ-034 SHALL impose no timeout: any stall on w_ctrl_state, RVALID or outready SHALL hold the state indefinitely.

Reset
REQ-035 resetn low SHALL asynchronously force state IDLE from any state, including mid-word and mid-pad.
REQ-036 resetn low SHALL force RE=0, ADDR=BASE_ADDR, outen=0, outbyte=0, byte_cnt=0, busy=0 and DONE=0.
REQ-037 After resetn rises, no activity SHALL occur until start.

Configuration
REQ-038 Macro DUMPER_SECTOR_PAD_EN defined: PAD SHALL behave per REQ-028 and REQ-029.
REQ-039 Macro DUMPER_SECTOR_PAD_EN undefined: PAD logic SHALL be absent, the last data byte SHALL go directly to FIN, and byte_cnt SHALL end at DUMP_SIZE.

Verification
REQ-040 DUMP_SIZE=4, RDATA=32'hAABBCCDD, outready=1 -> outbyte DD,CC,BB,AA on 4 consecutive cycles; with pad, 508 bytes of 00 follow; DONE=1 and byte_cnt=512.
REQ-041 DUMP_SIZE=8, BASE_ADDR=32'h100 -> ADDR is 32'h100 and then 32'h104; RE goes high only while w_ctrl_state==0 and falls in the first cycle w_ctrl_state!=0.
REQ-042 outready low for 10 cycles during the 2nd byte -> outbyte holds CC, byte_cnt does not advance, and the stream resumes without loss or duplication.
REQ-043 resetn pulsed low mid-pad at byte_cnt=300 -> all outputs take reset values immediately; a later start dumps from BASE_ADDR with byte_cnt from 0.
REQ-044 start pulsed while busy, and RVALID pulsed in SHIFT -> no effect; after DONE, start restarts the dump and clears DONE.
REQ-045 Pad macro undefined, DUMP_SIZE=516 -> no 00 bytes follow the last data byte; DONE=1 and byte_cnt=516.
